// File: rtl/ipsl_pcie_dma_mwr_sched.sv
// ipsl_pcie_dma_mwr_sched
// Splits one DMA write command into a sequence of PCIe memory-write TLPs.
// Each TLP is bounded by the programmed max payload size and by host 4 KB
// boundaries. The TLPs are handed one at a time to the read controller as
// a level request, and the block waits for that controller's last-data flag.
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   i_cmd_valid/o_cmd_ready   command handshake (ready only in IDLE)
//   i_cmd_addr            host byte address (bits [1:0] ignored)
//   i_cmd_ram_addr        local BAR RAM byte address (bits [1:0] ignored)
//   i_cmd_len_dw          total length in DW
//   i_max_payload_size    MPS encoding: 0=32 DW, 1=64 DW, >=2 -> 128 DW
//   o_rd_en/o_rd_length/o_rd_addr   read request towards the read controller
//   o_tlp_addr            host address of the current TLP
//   i_last_data           last beat of the current TLP left the read FIFO
//   o_busy, o_done, o_err status; o_done/o_err are one-cycle pulses
//   o_tlp_cnt             TLPs completed in the current or last command
module ipsl_pcie_dma_mwr_sched #(
  parameter logic [15:0] TIMEOUT_CYC = 16'd65535
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_cmd_valid,
  output logic        o_cmd_ready,
  input  logic [63:0] i_cmd_addr,
  input  logic [15:0] i_cmd_ram_addr,
  input  logic [15:0] i_cmd_len_dw,
  input  logic [2:0]  i_max_payload_size,
  output logic        o_rd_en,
  output logic [9:0]  o_rd_length,
  output logic [63:0] o_rd_addr,
  output logic [63:0] o_tlp_addr,
  input  logic        i_last_data,
  output logic        o_busy,
  output logic        o_done,
  output logic        o_err,
  output logic [15:0] o_tlp_cnt
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_XFER = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t      state_q, state_d;

  logic [63:0] haddr_q, haddr_d;
  logic [15:0] raddr_q, raddr_d;
  logic [15:0] remain_q, remain_d;
  logic [9:0]  rd_length_q, rd_length_d;
  logic [63:0] tlp_addr_q, tlp_addr_d;
  logic [15:0] rd_addr_q, rd_addr_d;
  logic [15:0] tlp_cnt_q, tlp_cnt_d;
  logic [15:0] wd_q, wd_d;
  logic        err_q, err_d;

  logic        wd_expire;
  logic        last_tlp;

  // Chunk = min(remain, MPS, DWs left before the next 4 KB host boundary).
  // The 4 KB term needs 11 bits because an aligned address leaves 1024 DW.
  function automatic logic [9:0] calc_chunk(input logic [15:0] remain,
                                            input logic [2:0]  mps,
                                            input logic [9:0]  dw_off);
    logic [10:0] lim;
    logic [10:0] to_4k;
    case (mps)
      3'd0:    lim = 11'd32;
      3'd1:    lim = 11'd64;
      default: lim = 11'd128;
    endcase
    to_4k = 11'd1024 - {1'b0, dw_off};
    if (to_4k < lim) lim = to_4k;
    if (remain < {5'd0, lim}) lim = remain[10:0];
    return lim[9:0];
  endfunction

  // Watchdog fires on the cycle the XFER counter would reach the limit.
  assign wd_expire = (TIMEOUT_CYC != 16'd0) && ((wd_q + 16'd1) == TIMEOUT_CYC);
  // chunk <= remain always, so equality means this TLP finishes the command.
  assign last_tlp  = (remain_q == {6'd0, rd_length_q});

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (i_cmd_valid) state_d = (i_cmd_len_dw == 16'd0) ? S_DONE : S_CALC;
      end
      S_CALC: state_d = S_XFER;
      S_XFER: begin
        if (i_last_data)    state_d = last_tlp ? S_DONE : S_CALC;
        else if (wd_expire) state_d = S_DONE;
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    o_cmd_ready = (state_q == S_IDLE);
    o_busy      = (state_q != S_IDLE);
    o_rd_en     = (state_q == S_XFER);
    o_done      = (state_q == S_DONE);
    o_err       = (state_q == S_DONE) && err_q;
  end

  assign o_rd_length = rd_length_q;
  assign o_tlp_addr  = tlp_addr_q;
  assign o_rd_addr   = {48'd0, rd_addr_q};
  assign o_tlp_cnt   = tlp_cnt_q;

  // Datapath and counters
  always_comb begin
    haddr_d     = haddr_q;
    raddr_d     = raddr_q;
    remain_d    = remain_q;
    rd_length_d = rd_length_q;
    tlp_addr_d  = tlp_addr_q;
    rd_addr_d   = rd_addr_q;
    tlp_cnt_d   = tlp_cnt_q;
    wd_d        = wd_q;
    err_d       = err_q;
    case (state_q)
      S_IDLE: begin
        if (i_cmd_valid) begin
          haddr_d   = {i_cmd_addr[63:2], 2'b00};
          raddr_d   = {i_cmd_ram_addr[15:2], 2'b00};
          remain_d  = i_cmd_len_dw;
          tlp_cnt_d = 16'd0;
        end
      end
      S_CALC: begin
        rd_length_d = calc_chunk(remain_q, i_max_payload_size, haddr_q[11:2]);
        tlp_addr_d  = haddr_q;
        rd_addr_d   = raddr_q;
        wd_d        = 16'd0;
      end
      S_XFER: begin
        if (i_last_data) begin
          haddr_d   = haddr_q + {52'd0, rd_length_q, 2'b00};
          raddr_d   = raddr_q + {4'd0, rd_length_q, 2'b00};
          remain_d  = remain_q - {6'd0, rd_length_q};
          tlp_cnt_d = tlp_cnt_q + 16'd1;
        end else if (wd_expire) begin
          err_d = 1'b1;
        end else begin
          wd_d = wd_q + 16'd1;
        end
      end
      S_DONE: err_d = 1'b0;
      default: ;
    endcase
  end

  // Visible outputs and control counters clear on reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_length_q <= 10'd0;
      tlp_addr_q  <= 64'd0;
      rd_addr_q   <= 16'd0;
      tlp_cnt_q   <= 16'd0;
      wd_q        <= 16'd0;
      err_q       <= 1'b0;
    end else begin
      rd_length_q <= rd_length_d;
      tlp_addr_q  <= tlp_addr_d;
      rd_addr_q   <= rd_addr_d;
      tlp_cnt_q   <= tlp_cnt_d;
      wd_q        <= wd_d;
      err_q       <= err_d;
    end
  end

  // Working address/length registers are always loaded in IDLE before use
  always_ff @(posedge clk) begin
    haddr_q  <= haddr_d;
    raddr_q  <= raddr_d;
    remain_q <= remain_d;
  end

endmodule

// File: doc/ipsl_pcie_dma_mwr_sched.md
# ipsl_pcie_dma_mwr_sched

Splits one DMA write command (host address, local BAR RAM address, total length in DW) into a sequence of PCIe memory-write TLPs. Each TLP is bounded by the programmed max payload size and by host 4 KB boundaries. The block drives the rising-edge-triggered read request (`rd_en`/`rd_length`/`rd_addr`) of `ipsl_pcie_dma_rd_ctrl` one TLP at a time. It waits for that block's last-data flag before issuing the next TLP.

## Interface
- `TIMEOUT_CYC`, default 16'd65535: XFER-state watchdog limit in cycles; 0 disables the watchdog.
- `clk` in 1: clock (gen1 62.5 MHz, gen2 125 MHz).
- `rst_n` in 1: reset, asynchronous, active-low.
- `i_cmd_valid` in 1: command request.
- `o_cmd_ready` out 1: high only in IDLE.
- `i_cmd_addr` in 64: host byte address; bits [1:0] ignored.
- `i_cmd_ram_addr` in 16: local BAR RAM byte address; bits [1:0] ignored.
- `i_cmd_len_dw` in 16: total length in DW.
- `i_max_payload_size` in 3: PCIe MPS encoding. 0 = 32 DW, 1 = 64 DW, 2 and above = 128 DW.
- `o_rd_en` out 1: high for the whole of each TLP.
- `o_rd_length` out 10: TLP length in DW.
- `o_rd_addr` out 64: `{48'b0, ram_addr}`, sent to the read controller.
- `o_tlp_addr` out 64: host address of the current TLP, sent to the header generator.
- `i_last_data` in 1: last beat of the current TLP has left the read FIFO.
- `o_busy` out 1: state is not IDLE.
- `o_done` out 1: one-cycle pulse when a command finishes.
- `o_err` out 1: one-cycle pulse, coincident with `o_done`, on watchdog abort.
- `o_tlp_cnt` out 16: TLPs completed in the current or last command.

## Operation
- FSM states: IDLE, CALC, XFER, DONE.
- **IDLE**
  - `o_cmd_ready` = 1.
  - On `i_cmd_valid`, latch `haddr`, `raddr` and `remain` = `i_cmd_len_dw`, and clear `o_tlp_cnt`.
  - Next state is DONE if `remain` == 0, otherwise CALC.
- **CALC** (one cycle, `o_rd_en` = 0)
  - `chunk` = min(`remain`, MPS_DW, 1024 − `haddr[11:2]`).
  - Register `o_rd_length` = `chunk`, `o_tlp_addr` = `haddr`, `o_rd_addr` = `raddr`.
  - Clear the watchdog counter.
  - Next state is XFER.
- **XFER**
  - `o_rd_en` = 1; length and address outputs are held constant.
  - On `i_last_data`:
    - `haddr` += `chunk`×4 (64-bit add).
    - `raddr` += `chunk`×4 (wraps modulo 2^16).
    - `remain` −= `chunk`.
    - `o_tlp_cnt` += 1.
    - Next state is DONE if the new `remain` == 0, otherwise CALC.
  - Watchdog: if `TIMEOUT_CYC` ≠ 0 and the counter reaches `TIMEOUT_CYC` with no `i_last_data`, set the error flag and go to DONE. Remaining length is discarded.
- **DONE**
  - `o_done` = 1 for this one cycle; `o_err` = error flag.
  - Clear the error flag.
  - Next state is IDLE.
- Width rules:
  - `chunk` never exceeds 128, so it always fits in 10 bits.
  - The 4 KB term is computed in 11 bits (maximum 1024).
  - `remain` is 16 bits and never underflows, because `chunk` ≤ `remain`.
- `i_last_data` outside XFER is ignored.
- `i_max_payload_size` is sampled in each CALC, so a change takes effect at the next TLP.

## Timing
- Reset values: `o_cmd_ready` = 1; every other output = 0; state = IDLE.
- Handshake at edge T (IDLE):
  - CALC in cycle T+1.
  - `o_rd_en` rises in cycle T+2, with length and addresses already valid.
- Between TLPs, `o_rd_en` is low for exactly one cycle (CALC). This guarantees the read controller sees a rising edge.
- `i_last_data` sampled high in cycle N:
  - `o_rd_en` = 0 in cycle N+1.
  - If the command is complete, `o_done` pulses in cycle N+1.
- Zero-length command: `o_done` is high in the cycle after the handshake, and `o_rd_en` never asserts.
- Watchdog abort: `o_rd_en` falls in the cycle after the limit is reached.
- Reset mid-XFER: all outputs clear immediately (asynchronous) and the command is lost.
- A new command cannot be accepted in the same cycle as `o_done`; the earliest acceptance is the following cycle.

## Test plan
- **Split by MPS:** addr 0x1000, ram 0x0000, len 64, MPS 0, ack each TLP.
  - Required: 2 TLPs, each length 32.
  - Host addresses 0x1000 then 0x1080; RAM addresses 0x0000 then 0x0080.
  - `o_done` with `o_tlp_cnt` = 2.
- **4 KB boundary:** addr 0x0FF0, len 16, MPS 1.
  - Required: TLP1 length 4 at 0x0FF0, then TLP2 length 12 at 0x1000.
- **Large MPS encoding:** MPS 5, len 300.
  - Required: lengths 128, 128, 44; `o_tlp_cnt` = 3.
  - `o_rd_en` is low for exactly 1 cycle between TLPs.
- **Zero length:** len 0.
  - Required: `o_done` pulses at T+1, `o_rd_en` stays 0, `o_tlp_cnt` = 0.
- **Watchdog:** `TIMEOUT_CYC` = 100, `i_last_data` never asserted.
  - Required: `o_rd_en` drops about 100 cycles into XFER; `o_done` and `o_err` pulse together; the next command is accepted.
- **Reset mid-transfer:** assert `rst_n` low during XFER.
  - Required: all outputs are 0 immediately and `o_cmd_ready` = 1.
  - A stray `i_last_data` after reset does not change any output.
